// File: rtl/instruction_mem_responder.sv
// Instruction-store read responder: one 128-bit word per request after RD_LATENCY cycles,
// followed by a read_done pulse; host loads the store through a 32-bit lane write port.
//
// state  | meaning
// IDLE   | waiting for a read request
// WAIT   | latency countdown, array read when the counter reaches 0
// RESP   | read_data/read_valid presented
// DONE   | read_done pulse, new request may be accepted
module instruction_mem_responder #(
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  axi_araddr,
   input  logic         axi_read_txn,
   output logic [127:0] read_data,
   output logic         read_valid,
   output logic         read_done,
   input  logic         wr_en,
   input  logic [31:0]  wr_addr,
   input  logic [31:0]  wr_data,
   output logic         busy,
   output logic         rd_err,
   output logic         ovr_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic          r_idx_ok;
   logic [127:0]  r_rdata;
   logic          r_rd_err;
   logic          r_ovr_err;
   logic [127:0]  r_mem [DEPTH];

   logic          w_rd_ok;
   logic          w_wr_ok;
   logic [AW-1:0] w_wr_idx;
   logic          w_unused;

   assign w_rd_ok  = (axi_araddr[31:4] < 28'(DEPTH));
   assign w_wr_ok  = (wr_addr[31:4] < 28'(DEPTH));
   assign w_wr_idx = wr_addr[AW+3:4];
   assign w_unused = ^{axi_araddr[3:0], wr_addr[1:0]};

   // Store is not reset; non-blocking update gives read-first on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (wr_en && w_wr_ok)
         r_mem[w_wr_idx][{wr_addr[3:2], 5'b0} +: 32] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_idx     <= '0;
         r_idx_ok  <= 1'b0;
         r_rdata   <= 128'd0;
         r_rd_err  <= 1'b0;
         r_ovr_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (axi_read_txn) begin
                  r_idx    <= axi_araddr[AW+3:4];
                  r_idx_ok <= w_rd_ok;
                  r_cnt    <= 4'(RD_LATENCY - 1);
                  r_state  <= S_WAIT;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (axi_read_txn)
                  r_ovr_err <= 1'b1;
               if (r_cnt == 4'd0) begin
                  // Out-of-range returns all zeros: opcode 000 halts the fetcher.
                  r_rdata <= r_idx_ok ? r_mem[r_idx] : 128'd0;
                  if (!r_idx_ok)
                     r_rd_err <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (axi_read_txn)
                  r_ovr_err <= 1'b1;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign read_data  = r_rdata;
   assign read_valid = (r_state == S_RESP);
   assign read_done  = (r_state == S_DONE);
   assign busy       = (r_state == S_WAIT) || (r_state == S_RESP);
   assign rd_err     = r_rd_err;
   assign ovr_err    = r_ovr_err;

endmodule

// File: tb/tb_instruction_mem_responder.sv
// Bench for instruction_mem_responder: two instances (latency 2 / depth 256, latency 1 / depth 16)
// checked against an array model of the instruction store and the handshake timing rules.
module tb_instruction_mem_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         txn    [2];
   logic [31:0]  araddr [2];
   logic         we     [2];
   logic [31:0]  wa     [2];
   logic [31:0]  wd     [2];
   logic [127:0] rdata  [2];
   logic         rv     [2];
   logic         rdn    [2];
   logic         bsy    [2];
   logic         rerr   [2];
   logic         oerr   [2];

   int n_chk = 0;
   int n_err = 0;

   int           DEP [2] = '{256, 16};
   int           LAT [2] = '{2, 1};
   logic [127:0] m_mem  [2][256];
   logic         m_rerr [2];
   logic         m_oerr [2];

   always #5 clk = ~clk;

   instruction_mem_responder #(.DEPTH(256), .RD_LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst), .axi_araddr(araddr[0]), .axi_read_txn(txn[0]),
      .read_data(rdata[0]), .read_valid(rv[0]), .read_done(rdn[0]),
      .wr_en(we[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
      .busy(bsy[0]), .rd_err(rerr[0]), .ovr_err(oerr[0]));

   instruction_mem_responder #(.DEPTH(16), .RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .axi_araddr(araddr[1]), .axi_read_txn(txn[1]),
      .read_data(rdata[1]), .read_valid(rv[1]), .read_done(rdn[1]),
      .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
      .busy(bsy[1]), .rd_err(rerr[1]), .ovr_err(oerr[1]));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, 128'(obs), 128'(exp));
   endtask

   function automatic logic in_range(input int w, input logic [31:0] a);
      return (a >> 4) < 32'(DEP[w]);
   endfunction

   function automatic logic [127:0] m_read(input int w, input logic [31:0] a);
      return in_range(w, a) ? m_mem[w][a >> 4] : 128'd0;
   endfunction

   function automatic void m_write(input int w, input logic [31:0] a, input logic [31:0] d);
      if (in_range(w, a))
         m_mem[w][a >> 4][32 * int'(a[3:2]) +: 32] = d;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hwrite(input int w, input logic [31:0] a, input logic [31:0] d);
      we[w] = 1'b1; wa[w] = a; wd[w] = d;
      @(negedge clk);
      we[w] = 1'b0;
      m_write(w, a, d);
   endtask

   // One full read handshake; returns at the read_done cycle.
   task automatic rd(input int w, input logic [31:0] a);
      logic [127:0] exp;
      int lat;
      exp = m_read(w, a);
      araddr[w] = a; txn[w] = 1'b1;
      @(negedge clk);
      txn[w] = 1'b0;
      lat = 0;
      while (!rv[w] && lat < 20) begin
         chk1("busy_wait", bsy[w], 1'b1);
         @(negedge clk);
         lat++;
      end
      chk("latency", 128'(lat), 128'(LAT[w]));
      chk("read_data", rdata[w], exp);
      if (!in_range(w, a)) m_rerr[w] = 1'b1;
      chk1("rd_err", rerr[w], m_rerr[w]);
      @(negedge clk);
      chk1("read_done", rdn[w], 1'b1);
      chk1("valid_single", rv[w], 1'b0);
      chk1("busy_done", bsy[w], 1'b0);
      chk("data_hold", rdata[w], exp);
   endtask

   task automatic chk_all_zero(input int w);
      chk("rst_data", rdata[w], 128'd0);
      chk1("rst_valid", rv[w], 1'b0);
      chk1("rst_done", rdn[w], 1'b0);
      chk1("rst_busy", bsy[w], 1'b0);
      chk1("rst_rd_err", rerr[w], 1'b0);
      chk1("rst_ovr_err", oerr[w], 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [127:0] old;
      logic [31:0] a;
      logic [31:0] seq [7];
      for (int w = 0; w < 2; w++) begin
         txn[w] = 1'b0; araddr[w] = 32'd0; we[w] = 1'b0; wa[w] = 32'd0; wd[w] = 32'd0;
         m_rerr[w] = 1'b0; m_oerr[w] = 1'b0;
      end
      idle(3);
      for (int w = 0; w < 2; w++) chk_all_zero(w);
      rst = 1'b0;
      idle(1);

      for (int w = 0; w < 2; w++)
         for (int i = 0; i < DEP[w]; i++)
            for (int l = 0; l < 4; l++)
               hwrite(w, 32'(i * 16 + l * 4), $urandom);

      // Word 0 directed contents and first read.
      hwrite(0, 32'h0, 32'h0000_0010);
      hwrite(0, 32'h4, 32'h0);
      hwrite(0, 32'h8, 32'h0000_0000);
      hwrite(0, 32'hC, 32'hA000_0000);
      rd(0, 32'h0);
      chk("word0_const", rdata[0], 128'hA0000000_00000000_00000000_00000010);
      idle(1);

      rd(0, 32'h0000_001C);
      idle(1);
      rd(0, 32'h0000_1000);
      idle(1);
      rd(0, 32'h0000_0020);
      chk1("rd_err_sticky", rerr[0], 1'b1);
      idle(1);

      // Second request one cycle after the first is dropped.
      old = m_read(0, 32'h30);
      araddr[0] = 32'h30; txn[0] = 1'b1;
      @(negedge clk);
      araddr[0] = 32'h40;
      @(negedge clk);
      txn[0] = 1'b0;
      m_oerr[0] = 1'b1;
      @(negedge clk);
      chk1("ovr_valid", rv[0], 1'b1);
      chk("ovr_data", rdata[0], old);
      chk1("ovr_err", oerr[0], m_oerr[0]);
      @(negedge clk);
      chk1("ovr_done", rdn[0], 1'b1);
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rv[0]) cnt++;
      end
      chk("ovr_no_extra_valid", 128'(cnt), 128'd0);

      // Request in the read_done cycle is accepted.
      rd(0, 32'h50);
      rd(0, 32'h60);
      chk1("ovr_err_sticky", oerr[0], 1'b1);
      idle(1);

      // Same-cycle write of word 5 during its read returns the old data.
      old = m_read(0, 32'h50);
      araddr[0] = 32'h50; txn[0] = 1'b1;
      @(negedge clk);
      txn[0] = 1'b0;
      @(negedge clk);
      a = $urandom;
      we[0] = 1'b1; wa[0] = 32'h5C; wd[0] = a;
      @(negedge clk);
      we[0] = 1'b0;
      m_write(0, 32'h5C, a);
      chk1("rf_valid", rv[0], 1'b1);
      chk("read_first", rdata[0], old);
      idle(2);
      rd(0, 32'h50);
      chk("reread_new_lane3", rdata[0][127:96], 128'(a));
      idle(1);

      // Latency-1 instance basic reads.
      rd(1, 32'h30);
      idle(1);
      rd(1, 32'h100);
      idle(1);

      // Reset one cycle after a request aborts it on both instances.
      araddr[0] = 32'h20; txn[0] = 1'b1;
      araddr[1] = 32'h20; txn[1] = 1'b1;
      @(negedge clk);
      txn[0] = 1'b0; txn[1] = 1'b0;
      rst = 1'b1;
      for (int w = 0; w < 2; w++) begin m_rerr[w] = 1'b0; m_oerr[w] = 1'b0; end
      @(negedge clk);
      for (int w = 0; w < 2; w++) chk_all_zero(w);
      rst = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rv[0] || rdn[0] || rv[1] || rdn[1]) cnt++;
      end
      chk("abort_no_response", 128'(cnt), 128'd0);
      rd(0, 32'h20);
      idle(1);
      rd(1, 32'h20);
      idle(1);

      // Randomised mix of host writes and reads.
      for (int i = 0; i < 40; i++) begin
         int w;
         w = int'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEP[w] * 16 - 1));
            hwrite(w, a, $urandom);
         end else begin
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, DEP[w] * 16 - 1));
            rd(w, a);
            idle(1);
         end
      end

      // Fetcher loop: segment word at 0, jump word at 16.
      hwrite(0, 32'h10, 32'h0000_0000);
      hwrite(0, 32'h14, 32'h0000_0001);
      hwrite(0, 32'h18, 32'h0000_0002);
      hwrite(0, 32'h1C, 32'hE000_0000);
      seq = '{32'h0, 32'h10, 32'h0, 32'h10, 32'h0, 32'h10, 32'h20};
      for (int i = 0; i < 7; i++) begin
         rd(0, seq[i]);
         idle(1);
      end
      chk1("final_rd_err", rerr[0], m_rerr[0]);
      chk1("final_ovr_err", oerr[0], m_oerr[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_mem_responder.md
Name: instruction_mem_responder

Overview:
- Responder end of the instruction-fetch read interface.
- Accepts a single-cycle read request (axi_araddr + axi_read_txn pulse) from the instruction fetcher and returns one 128-bit instruction word with a read_valid pulse and a trailing read_done pulse.
- Holds the instruction store in an internal array. A host loads the array through a 32-bit lane write port.
- Sits between the host/config path and the waveform instruction fetcher.

Parameters:
- DEPTH, 256, number of 128-bit instruction words (power of 2, >=2)
- RD_LATENCY, 2, cycles from accepted request to read_valid (1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- axi_araddr  in  32  byte address of requested instruction
- axi_read_txn  in  1  one-cycle read request strobe
- read_data  out  128  returned instruction word
- read_valid  out  1  one-cycle pulse, read_data valid
- read_done  out  1  one-cycle pulse, transaction complete
- wr_en  in  1  host lane write strobe
- wr_addr  in  32  host byte address; [3:2] selects lane, upper bits select word
- wr_data  in  32  host write data
- busy  out  1  high while a read is outstanding
- rd_err  out  1  sticky: out-of-range read occurred
- ovr_err  out  1  sticky: request dropped while busy

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; read_data is 128'd0; state is IDLE; latency counter is 0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it; no read_valid or read_done is produced afterwards.
- Addressing:
  - Word index = axi_araddr[31:4]; axi_araddr[3:0] is ignored.
  - A read is in range if the index is < DEPTH.
  - Write lane n = wr_addr[3:2] covers bits [32n+31:32n]; lane 3 holds the opcode bits [127:125].
  - Out-of-range writes are ignored with no flag.
- Writes:
  - Performed on any cycle wr_en=1, independent of the read state machine.
  - Write to a word in the same cycle it is read from the array: the read returns the old contents (read-first).
- State machine:
  - IDLE: busy=0. On axi_read_txn=1, latch the word index and go to WAIT with counter = RD_LATENCY-1.
  - WAIT: busy=1. Decrement the counter each cycle. When the counter is 0, read the array and go to RESP.
    - With RD_LATENCY=1, WAIT lasts one cycle.
  - RESP: drive read_data and read_valid=1 for exactly one cycle, then go to DONE.
  - DONE: read_done=1 for one cycle, busy=0; go to IDLE.
    - A request arriving in DONE is accepted as if in IDLE (go to WAIT).
- Latency:
  - Request sampled at edge T gives read_valid high during cycle T+RD_LATENCY and read_done during T+RD_LATENCY+1.
  - The next request can be accepted at the edge ending the read_done cycle.
- read_data holds its value until the next RESP; it is not cleared in IDLE.
- Out-of-range read: the full handshake still completes, read_data=128'd0 (opcode 000, so the fetcher halts), and rd_err is set.
- axi_read_txn=1 in WAIT or RESP: the request is dropped, ovr_err is set, and the outstanding transaction is unaffected.
- Sticky flags clear only on rst.
- Back-to-back requests are accepted only via IDLE/DONE. Single outstanding transaction, no queueing.

Test Plan:
- Host writes lanes 0..3 of word 0 = 32'h0000_0010, 0, 32'h0000_0000, 32'hA000_0000; txn at araddr 0 (RD_LATENCY=2) -> read_valid exactly 2 cycles after txn with read_data=128'hA0000000_00000000_00000000_00000010, read_done next cycle, busy high for both intervening cycles.
- araddr 32'h0000_001C -> returns word 1 (low bits ignored). Then araddr 32'h0000_1000 with DEPTH=256 (index 256) -> read_data=0, read_valid and read_done still pulse, rd_err=1 and stays 1.
- Second txn asserted 1 cycle after the first -> single read_valid for the first address only, ovr_err=1. Txn asserted in the read_done cycle -> accepted, read_valid 2 cycles later.
- Host write of lane 3 of word 5 in the same cycle word 5 is read -> old data returned; re-read -> new data.
- rst pulsed 1 cycle after txn -> no read_valid/read_done ever appears, all outputs 0, and a subsequent txn completes normally. Repeat with RD_LATENCY=1: read_valid 1 cycle after txn.
- Fetcher loop: segment word at 0, jump word (opcode 111, jump_addr 0, counter 1, times 2) at 16 -> responder serves addresses 0,16,0,16,0,16,32 in order, each with a single read_valid.
